// File: rtl/tug_round_ctrl.sv
// Tug-of-war round sequencer: button edge detect, READY countdown, PLAY arbitration,
// win display and saturating per-player scores.
module tug_round_ctrl #(
  parameter int READY_TICKS = 4,
  parameter int WIN_HOLD    = 8,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               pbl,
  input  logic               pbr,
  output logic [6:0]         leds_out,
  output logic [3:0]         status,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r
);

  // state   | meaning
  // IDLE    | waiting for start, rope shown centred
  // READY   | countdown; presses are false starts that penalise the presser
  // PLAY    | presses pull the rope toward the presser
  // WIN_L   | left player won, pattern held for WIN_HOLD ticks
  // WIN_R   | right player won, pattern held for WIN_HOLD ticks
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_WIN_L = 3'd3,
    S_WIN_R = 3'd4
  } state_t;

  localparam int RW = $clog2(READY_TICKS + 1);
  localparam int HW = $clog2(WIN_HOLD + 1);

  state_t        state;
  logic [2:0]    pos;
  logic [RW-1:0] ready_cnt;
  logic [HW-1:0] hold_cnt;
  logic          pbl_d, pbr_d;
  logic          press_l, press_r;

  assign press_l = pbl & ~pbl_d;
  assign press_r = pbr & ~pbr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pos       <= 3'd3;
      ready_cnt <= '0;
      hold_cnt  <= '0;
      pbl_d     <= 1'b0;
      pbr_d     <= 1'b0;
      score_l   <= '0;
      score_r   <= '0;
    end else begin
      pbl_d <= pbl;
      pbr_d <= pbr;
      case (state)
        S_IDLE: begin
          if (start) begin
            pos       <= 3'd3;
            ready_cnt <= RW'(READY_TICKS);
            state     <= S_READY;
          end
        end
        S_READY: begin
          // clamp to 1..5 so a false start can never decide the round
          if (press_l && !press_r && pos < 3'd5)
            pos <= pos + 3'd1;
          else if (press_r && !press_l && pos > 3'd1)
            pos <= pos - 3'd1;
          if (tick) begin
            ready_cnt <= ready_cnt - RW'(1);
            if (ready_cnt == RW'(1))
              state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (press_l && !press_r && pos != 3'd0) begin
            pos <= pos - 3'd1;
            if (pos == 3'd1) begin
              state    <= S_WIN_L;
              hold_cnt <= HW'(WIN_HOLD);
              if (score_l != '1) score_l <= score_l + 1'b1;
            end
          end else if (press_r && !press_l && pos != 3'd6) begin
            pos <= pos + 3'd1;
            if (pos == 3'd5) begin
              state    <= S_WIN_R;
              hold_cnt <= HW'(WIN_HOLD);
              if (score_r != '1) score_r <= score_r + 1'b1;
            end
          end
        end
        S_WIN_L, S_WIN_R: begin
          if (tick) begin
            hold_cnt <= hold_cnt - HW'(1);
            if (hold_cnt == HW'(1))
              state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    leds_out = 7'b0001000;
    status   = 4'b1111;
    case (state)
      S_READY: begin leds_out = 7'b0000001 << pos; status = 4'b1110; end
      S_PLAY:  begin leds_out = 7'b0000001 << pos; status = 4'b1101; end
      S_WIN_L: begin leds_out = 7'b0000111;        status = 4'b1011; end
      S_WIN_R: begin leds_out = 7'b1110000;        status = 4'b0111; end
      default: begin leds_out = 7'b0001000;        status = 4'b1111; end
    endcase
  end

endmodule

// File: tb/tb_tug_round_ctrl.sv
// Directed bench for tug_round_ctrl; expected outputs are queued per step and
// compared against the DUT when the step's cycles have elapsed.
module tb_tug_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, start, pbl, pbr;
  logic [6:0] leds_out;
  logic [3:0] status;
  logic [3:0] score_l, score_r;

  tug_round_ctrl #(.READY_TICKS(4), .WIN_HOLD(8), .SCORE_W(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pbl(pbl), .pbr(pbr),
    .leds_out(leds_out), .status(status), .score_l(score_l), .score_r(score_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [18:0] v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_sr;

  localparam logic [3:0] ST_IDLE  = 4'b1111;
  localparam logic [3:0] ST_READY = 4'b1110;
  localparam logic [3:0] ST_PLAY  = 4'b1101;
  localparam logic [3:0] ST_WINL  = 4'b1011;
  localparam logic [3:0] ST_WINR  = 4'b0111;

  function automatic logic [6:0] rope(input int p);
    logic [6:0] one;
    one = 7'b0000001;
    return one << p;
  endfunction

  task automatic push(input string tag, input logic [6:0] l, input logic [3:0] s,
                      input int sl, input int sr);
    exp_t e;
    e.tag = tag;
    e.v   = {l, s, 4'(sl), 4'(sr)};
    q.push_back(e);
  endtask

  task automatic chk();
    exp_t        e;
    logic [18:0] act;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = {leds_out, status, score_l, score_r};
      n_cmp++;
      assert (act === e.v) else begin
        n_err++;
        $error("FAIL %s: observed leds=%b status=%b sl=%0d sr=%0d expected leds=%b status=%b sl=%0d sr=%0d",
               e.tag, act[18:12], act[11:8], act[7:4], act[3:0],
               e.v[18:12], e.v[11:8], e.v[7:4], e.v[3:0]);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tk(input int n);
    repeat (n) begin
      tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
    end
  endtask

  task automatic do_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic tap_l();
    pbl = 1'b1; cyc(1); pbl = 1'b0; cyc(1);
  endtask

  task automatic tap_r();
    pbr = 1'b1; cyc(1); pbr = 1'b0; cyc(1);
  endtask

  task automatic right_round(input int sl);
    do_start();
    tk(4);
    tap_r(); tap_r(); tap_r();
    exp_sr = (exp_sr < 15) ? exp_sr + 1 : 15;
    push("win_r_show", 7'b1110000, ST_WINR, sl, exp_sr);
    chk();
    tk(8);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; pbl = 1'b0; pbr = 1'b0;
    exp_sr = 0;
    cyc(1);
    rst = 1'b0;
    push("reset", 7'b0001000, ST_IDLE, 0, 0); chk();

    pbl = 1'b1; cyc(2); pbr = 1'b1; pbl = 1'b0; cyc(2); pbr = 1'b0; tick = 1'b1; cyc(1); tick = 1'b0;
    push("idle_ignore", 7'b0001000, ST_IDLE, 0, 0); chk();

    do_start();
    push("ready_entry", rope(3), ST_READY, 0, 0); chk();
    tk(3);
    push("ready_3ticks", rope(3), ST_READY, 0, 0); chk();
    tk(1);
    push("play_entry", rope(3), ST_PLAY, 0, 0); chk();

    pbl = 1'b1; cyc(20); pbl = 1'b0; cyc(1);
    push("held_once", rope(2), ST_PLAY, 0, 0); chk();
    pbl = 1'b1; pbr = 1'b1; cyc(1); pbl = 1'b0; pbr = 1'b0; cyc(1);
    push("simul_nochg", rope(2), ST_PLAY, 0, 0); chk();
    tk(2); start = 1'b1; cyc(1); start = 1'b0;
    push("play_tick_start", rope(2), ST_PLAY, 0, 0); chk();
    tap_l();
    push("play_pos1", rope(1), ST_PLAY, 0, 0); chk();
    tap_l();
    push("win_l_show", 7'b0000111, ST_WINL, 1, 0); chk();
    tap_r(); tap_l(); do_start();
    push("win_ignore", 7'b0000111, ST_WINL, 1, 0); chk();
    tk(7);
    push("win_hold7", 7'b0000111, ST_WINL, 1, 0); chk();
    tk(1);
    push("win_to_idle", 7'b0001000, ST_IDLE, 1, 0); chk();

    do_start();
    tap_r();
    push("fs_pos2", rope(2), ST_READY, 1, 0); chk();
    tap_r(); tap_r();
    push("fs_clamp1", rope(1), ST_READY, 1, 0); chk();
    tap_l();
    push("fs_left_pos2", rope(2), ST_READY, 1, 0); chk();
    pbr = 1'b1; tick = 1'b1; cyc(1); pbr = 1'b0; tick = 1'b0; cyc(1);
    push("fs_with_tick", rope(1), ST_READY, 1, 0); chk();
    tk(3);
    push("fs_play_pos1", 7'b0000010, ST_PLAY, 1, 0); chk();
    tap_l();
    push("fs_win_l", 7'b0000111, ST_WINL, 2, 0); chk();
    tk(8);

    right_round(2);
    right_round(2);
    push("two_right", 7'b0001000, ST_IDLE, 2, 2); chk();
    do_start(); tk(4); tap_r(); tap_r();
    push("mid_play_pos5", rope(5), ST_PLAY, 2, 2); chk();
    rst = 1'b1; cyc(1); rst = 1'b0;
    push("mid_reset", 7'b0001000, ST_IDLE, 0, 0); chk();
    do_start();
    push("post_reset_pos3", rope(3), ST_READY, 0, 0); chk();
    tk(4);

    exp_sr = 0;
    // bring back to idle from PLAY by finishing a right round, then keep going
    tap_r(); tap_r(); tap_r();
    exp_sr = 1;
    push("sat_first", 7'b1110000, ST_WINR, 0, exp_sr); chk();
    tk(8);
    for (int i = 0; i < 15; i++) right_round(0);
    push("sat_hold15", 7'b0001000, ST_IDLE, 0, 15); chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tug_round_ctrl.md
Name: tug_round_ctrl

Overview:
Round sequencer for the tug-of-war game. Edge-detects the two player pushbuttons and runs the READY countdown, PLAY and win-display phases. Arbitrates simultaneous pulls, tracks rope position, detects a win and keeps per-player scores. Drives the 7 board LEDs and the 4 active-low status LEDs; sits between the synchronised pushbuttons and the board outputs.

Parameters:
READY_TICKS, 4, tick pulses spent in READY before PLAY (>=1)
WIN_HOLD, 8, tick pulses the win pattern is shown before returning to IDLE (>=1)
SCORE_W, 4, width of each score counter

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
tick  input  1  one-cycle slow timebase enable pulse
start  input  1  level; begins a round when sampled high in IDLE
pbl  input  1  left player button, already synchronised, level
pbr  input  1  right player button, already synchronised, level
leds_out  output  7  rope display; bit 0 = left end
status  output  4  active-low phase LEDs {WIN_R,WIN_L,PLAY,READY}
score_l  output  SCORE_W  left player wins
score_r  output  SCORE_W  right player wins

Behaviour:
- Reset (rst high at posedge clk): state=IDLE, pos=3, ready_cnt=0, hold_cnt=0, pbl_d=pbr_d=0, scores=0. Reset overrides everything, including mid-round; scores are cleared.
- Edge detect: press_l = pbl & ~pbl_d; press_r = pbr & ~pbr_d. pbl_d/pbr_d register every cycle in all states, so a held button gives exactly one press. A button already high when PLAY starts gives no press until released and re-pressed.
- pos is 3 bits, range 0..6. leds_out = 1<<pos in READY and PLAY.
- IDLE: leds_out=7'b0001000, status=4'b1111. If start: pos<=3, ready_cnt<=READY_TICKS, go READY. Presses ignored.
- READY: status=4'b1110. Each tick decrements ready_cnt. On tick with ready_cnt==1, go PLAY next cycle.
- False start in READY: press_l alone moves pos+1; press_r alone moves pos-1; both together, no change. pos is clamped to 1..5, so no win is possible in READY. Press and tick in the same cycle are both applied.
- PLAY: status=4'b1101. press_l&~press_r: pos-1. press_r&~press_l: pos+1. Both or neither: no change.
- Win detection: a move that makes pos=0 enters WIN_L next cycle, score_l+1; pos=6 enters WIN_R, score_r+1. The score updates on the same clock edge as the state change. Scores saturate at all-ones. hold_cnt<=WIN_HOLD.
- WIN_L: leds_out=7'b0000111, status=4'b1011. WIN_R: leds_out=7'b1110000, status=4'b0111.
- In WIN_L/WIN_R: presses and start are ignored. Each tick decrements hold_cnt. On tick with hold_cnt==1, go IDLE; pos and scores are retained.
- start is ignored outside IDLE. tick has no effect in IDLE or PLAY.
- All outputs are registered or decoded from registered state only, with no combinational path from inputs.
- Undefined state encodings return to IDLE on the next clock.

Test Plan:
1. Reset then idle: rst 1 cycle -> leds_out=0001000, status=1111, scores=0; pbl/pbr toggling changes nothing.
2. Countdown: pulse start, then 4 ticks -> READY for exactly 4 ticks (status=1110), then PLAY with leds_out=0001000.
3. Left win: in PLAY, 3 separate pbl presses -> pos 2,1,0; state WIN_L the cycle after the third, leds_out=0000111, score_l=1. After 8 ticks -> IDLE.
4. Held and simultaneous presses: hold pbl 20 cycles -> pos moves only once. pbl and pbr rising in the same cycle -> pos unchanged.
5. False start: press pbr 3 times during READY -> pos 2,1,1 (clamped at 1). PLAY begins at leds_out=0000010; a single pbl press then gives WIN_L.
6. Reset mid-PLAY at pos=5 with score_r=2 -> next cycle IDLE, pos=3, score_r=0. Saturation: 16 right wins with SCORE_W=4 -> score_r holds at 15.
